// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and execute-entry operand network of a 5-stage
// RISC-V core. It captures one decoded instruction per cycle and resolves RAW
// hazards by forwarding results from the MEM and WB stages into the ALU
// operands. When a load in EX feeds the instruction in decode, it stalls
// decode and inserts a single bubble.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   d_*                    decoded instruction (data, indices, control)
//   m_rd/m_reg_write/m_alu_result   EX/MEM forwarding source
//   w_rd/w_reg_write/w_result       MEM/WB forwarding source
//   flush_e                replace the instruction entering EX with a bubble
//   hold_e                 freeze the stage for a downstream stall
//   stall_d                freeze PC and IF/ID (load-use or hold)
//   e_valid, *_e           registered EX-slot contents
//   src_a, src_b           forwarded ALU operands
//   write_data_e           forwarded rs2 value for stores
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    // Decode stage
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_rd1,
    input  logic [XLEN-1:0] d_rd2,
    input  logic [XLEN-1:0] d_imm,
    input  logic [XLEN-1:0] d_pc,
    input  logic [4:0]      d_rs1,
    input  logic [4:0]      d_rs2,
    input  logic [4:0]      d_rd,
    input  logic [3:0]      d_alu_control,
    input  logic            d_alu_src,
    input  logic            d_reg_write,
    input  logic            d_mem_read,
    input  logic            d_mem_write,
    input  logic            d_branch,
    input  logic            d_jump,
    input  logic [1:0]      d_result_src,

    // Forwarding sources
    input  logic [4:0]      m_rd,
    input  logic            m_reg_write,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic [4:0]      w_rd,
    input  logic            w_reg_write,
    input  logic [XLEN-1:0] w_result,

    // Pipeline control
    input  logic            flush_e,
    input  logic            hold_e,
    output logic            stall_d,

    // Execute stage
    output logic            e_valid,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [3:0]      alu_control_e,
    output logic [XLEN-1:0] write_data_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] imm_e,
    output logic [4:0]      rd_e,
    output logic [1:0]      result_src_e,
    output logic            reg_write_e,
    output logic            mem_read_e,
    output logic            mem_write_e,
    output logic            branch_e,
    output logic            jump_e
);

    // Everything held in the EX slot. An all-zero slot is a bubble: not valid,
    // no side effects, and rd/rs indices of x0 so nothing forwards or hazards.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_control;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
    } ex_slot_t;

    // Operand source selected by the forwarding network.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    localparam ex_slot_t BUBBLE = '0;

    ex_slot_t ex_q;
    ex_slot_t ex_d;
    ex_slot_t dec_slot;
    logic     load_use;

    // -------------------------------------------------------------------------
    // Load-use hazard: the load in EX only has its data at the end of MEM, so
    // a dependent instruction in decode must wait one cycle and then pick the
    // value up from WB.
    // -------------------------------------------------------------------------
    assign load_use = d_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                      ((ex_q.rd == d_rs1) || (ex_q.rd == d_rs2));

    assign stall_d = load_use | hold_e;

    // Decode inputs packed into slot form.
    always_comb begin
        dec_slot.valid       = d_valid;
        dec_slot.rd1         = d_rd1;
        dec_slot.rd2         = d_rd2;
        dec_slot.imm         = d_imm;
        dec_slot.pc          = d_pc;
        dec_slot.rs1         = d_rs1;
        dec_slot.rs2         = d_rs2;
        dec_slot.rd          = d_rd;
        dec_slot.alu_control = d_alu_control;
        dec_slot.alu_src     = d_alu_src;
        dec_slot.reg_write   = d_reg_write;
        dec_slot.mem_read    = d_mem_read;
        dec_slot.mem_write   = d_mem_write;
        dec_slot.branch      = d_branch;
        dec_slot.jump        = d_jump;
        dec_slot.result_src  = d_result_src;
    end

    // -------------------------------------------------------------------------
    // Next-state selection. Flush beats hold so a taken branch always kills
    // the wrong-path instruction; hold beats load_use so the hazard check is
    // re-evaluated once the downstream stall releases.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves ex_d
        // unassigned, which would otherwise infer a latch.
        ex_d = ex_q;
        if (flush_e) begin
            ex_d = BUBBLE;
        end else if (hold_e) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = BUBBLE;
        end else begin
            ex_d = dec_slot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples its inputs from before the clock edge.
            ex_q <= ex_d;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding. MEM holds the younger result and wins over WB; x0 is never
    // forwarded since its architectural value is always zero. Runs even on a
    // bubble; the downstream enables are all zero then.
    // -------------------------------------------------------------------------
    function automatic fwd_sel_t fwd_select(input logic [4:0] rs);
        if (m_reg_write && (m_rd != 5'd0) && (m_rd == rs)) begin
            return FWD_MEM;
        end else if (w_reg_write && (w_rd != 5'd0) && (w_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_t sel,
                                                input logic [XLEN-1:0] rf_val);
        case (sel)
            FWD_MEM: return m_alu_result;
            FWD_WB:  return w_result;
            default: return rf_val;
        endcase
    endfunction

    fwd_sel_t        fwd_a_sel;
    fwd_sel_t        fwd_b_sel;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign fwd_a_sel = fwd_select(ex_q.rs1);
    assign fwd_b_sel = fwd_select(ex_q.rs2);
    assign fwd_rs1   = fwd_mux(fwd_a_sel, ex_q.rd1);
    assign fwd_rs2   = fwd_mux(fwd_b_sel, ex_q.rd2);

    assign src_a        = fwd_rs1;
    assign src_b        = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    // Stores need the forwarded rs2 even when SrcB is the offset immediate.
    assign write_data_e = fwd_rs2;

    // -------------------------------------------------------------------------
    // Registered EX outputs
    // -------------------------------------------------------------------------
    assign e_valid       = ex_q.valid;
    assign alu_control_e = ex_q.alu_control;
    assign pc_e          = ex_q.pc;
    assign imm_e         = ex_q.imm;
    assign rd_e          = ex_q.rd;
    assign result_src_e  = ex_q.result_src;
    assign reg_write_e   = ex_q.reg_write;
    assign mem_read_e    = ex_q.mem_read;
    assign mem_write_e   = ex_q.mem_write;
    assign branch_e      = ex_q.branch;
    assign jump_e        = ex_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A reference model tracks which
// instruction occupies EX and what the newest value of each source register
// is; one compare process checks every output on every falling edge. Directed
// scenarios with hand-computed literal expectations pin the model, followed by
// a long randomized run.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            d_valid;
    logic [XLEN-1:0] d_rd1, d_rd2, d_imm, d_pc;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [3:0]      d_alu_control;
    logic            d_alu_src, d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump;
    logic [1:0]      d_result_src;
    logic [4:0]      m_rd, w_rd;
    logic            m_reg_write, w_reg_write;
    logic [XLEN-1:0] m_alu_result, w_result;
    logic            flush_e, hold_e;
    logic            stall_d, e_valid;
    logic [XLEN-1:0] src_a, src_b, write_data_e, pc_e, imm_e;
    logic [3:0]      alu_control_e;
    logic [4:0]      rd_e;
    logic [1:0]      result_src_e;
    logic            reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_alu_control(d_alu_control),
        .d_alu_src(d_alu_src), .d_reg_write(d_reg_write), .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write), .d_branch(d_branch), .d_jump(d_jump),
        .d_result_src(d_result_src),
        .m_rd(m_rd), .m_reg_write(m_reg_write), .m_alu_result(m_alu_result),
        .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
        .flush_e(flush_e), .hold_e(hold_e), .stall_d(stall_d),
        .e_valid(e_valid), .src_a(src_a), .src_b(src_b),
        .alu_control_e(alu_control_e), .write_data_e(write_data_e),
        .pc_e(pc_e), .imm_e(imm_e), .rd_e(rd_e), .result_src_e(result_src_e),
        .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .jump_e(jump_e)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: the instruction currently in EX (all-zero = empty)
    // ------------------------------------------------------------------------
    typedef struct {
        bit          valid;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluc;
        bit          alu_src, reg_write, mem_read, mem_write, branch, jump;
        logic [1:0]  rsrc;
    } instr_t;

    instr_t model_ex;

    function automatic instr_t empty_slot();
        instr_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic instr_t decoded();
        instr_t s;
        s.valid = d_valid;          s.rd1 = d_rd1;         s.rd2 = d_rd2;
        s.imm = d_imm;              s.pc = d_pc;           s.rs1 = d_rs1;
        s.rs2 = d_rs2;              s.rd = d_rd;           s.aluc = d_alu_control;
        s.alu_src = d_alu_src;      s.reg_write = d_reg_write;
        s.mem_read = d_mem_read;    s.mem_write = d_mem_write;
        s.branch = d_branch;        s.jump = d_jump;       s.rsrc = d_result_src;
        return s;
    endfunction

    // A real load in EX whose destination is read by the decode instruction.
    function automatic bit model_hazard();
        return d_valid && model_ex.valid && model_ex.mem_read && (model_ex.rd != 0) &&
               (model_ex.rd == d_rs1 || model_ex.rd == d_rs2);
    endfunction

    // Newest architectural value of register idx: youngest in-flight writer
    // first, register-file read otherwise; x0 is always the read value.
    function automatic logic [31:0] newest_value(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (m_reg_write && m_rd == idx) return m_alu_result;
        if (w_reg_write && w_rd == idx) return w_result;
        return rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              model_ex <= empty_slot();
        else if (flush_e)        model_ex <= empty_slot();
        else if (hold_e)         model_ex <= model_ex;
        else if (model_hazard()) model_ex <= empty_slot();
        else                     model_ex <= decoded();
    end

    // Compare process: every output, every falling edge.
    always @(negedge clk) begin
        logic [31:0] exp_b;
        exp_b = model_ex.alu_src ? model_ex.imm : newest_value(model_ex.rs2, model_ex.rd2);
        check("cmp_e_valid", e_valid, model_ex.valid);
        check("cmp_stall_d", stall_d, model_hazard() | hold_e);
        check("cmp_src_a", src_a, newest_value(model_ex.rs1, model_ex.rd1));
        check("cmp_src_b", src_b, exp_b);
        check("cmp_write_data", write_data_e, newest_value(model_ex.rs2, model_ex.rd2));
        check("cmp_pc_e", pc_e, model_ex.pc);
        check("cmp_imm_e", imm_e, model_ex.imm);
        check("cmp_rd_e", rd_e, model_ex.rd);
        check("cmp_alu_control_e", alu_control_e, model_ex.aluc);
        check("cmp_result_src_e", result_src_e, model_ex.rsrc);
        check("cmp_ctrl", {reg_write_e, mem_read_e, mem_write_e, branch_e, jump_e},
              {model_ex.reg_write, model_ex.mem_read, model_ex.mem_write,
               model_ex.branch, model_ex.jump});
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic set_idle();
        d_valid = 0; d_rd1 = 0; d_rd2 = 0; d_imm = 0; d_pc = 0;
        d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_alu_control = 0; d_alu_src = 0;
        d_reg_write = 0; d_mem_read = 0; d_mem_write = 0; d_branch = 0; d_jump = 0;
        d_result_src = 0;
        m_rd = 0; m_reg_write = 0; m_alu_result = 0;
        w_rd = 0; w_reg_write = 0; w_result = 0;
        flush_e = 0; hold_e = 0;
    endtask

    task automatic rand_decode();
        logic [3:0] ops [4];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0011; ops[3] = 4'b0100;
        d_valid       = ($urandom_range(0, 3) != 0);
        d_rd1         = $urandom; d_rd2 = $urandom; d_imm = $urandom; d_pc = $urandom;
        d_rs1         = 5'($urandom_range(0, 7));
        d_rs2         = 5'($urandom_range(0, 7));
        d_rd          = 5'($urandom_range(0, 7));
        d_alu_control = ops[$urandom_range(0, 3)];
        d_alu_src     = 1'($urandom);
        d_reg_write   = 1'($urandom);
        d_mem_read    = ($urandom_range(0, 2) == 0);
        d_mem_write   = 1'($urandom);
        d_branch      = 1'($urandom);
        d_jump        = 1'($urandom);
        d_result_src  = 2'($urandom);
    endtask

    task automatic rand_all();
        rand_decode();
        m_rd = 5'($urandom_range(0, 7)); m_reg_write = 1'($urandom); m_alu_result = $urandom;
        w_rd = 5'($urandom_range(0, 7)); w_reg_write = 1'($urandom); w_result = $urandom;
        flush_e = ($urandom_range(0, 9) == 0);
        hold_e  = ($urandom_range(0, 6) == 0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios, then randomized run
    // ------------------------------------------------------------------------
    initial begin
        set_idle();
        #1 rst_n = 1'b0;

        // Reset with random decode inputs: nothing may leak into EX.
        rand_decode();
        d_valid = 1'b1;
        tick();
        tick();
        #1;
        check("rst_e_valid", e_valid, 0);
        check("rst_reg_write_e", reg_write_e, 0);
        check("rst_src_a", src_a, 0);
        check("rst_src_b", src_b, 0);
        check("rst_stall_d", stall_d, 0);

        // addi x5, x0, 7
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        d_valid = 1; d_rd = 5; d_imm = 7; d_alu_src = 1; d_reg_write = 1;
        tick();
        check("addi_src_b", src_b, 7);
        check("addi_rd_e", rd_e, 5);
        check("addi_e_valid", e_valid, 1);

        // MEM forwarding and MEM-over-WB priority on rs1 = x3.
        set_idle();
        d_valid = 1; d_rs1 = 3; d_rd1 = 32'h11; d_rd = 4;
        tick();
        m_rd = 3; m_reg_write = 1; m_alu_result = 32'hAA;
        #1 check("fwd_mem_src_a", src_a, 32'hAA);
        w_rd = 3; w_reg_write = 1; w_result = 32'hBB;
        #1 check("fwd_mem_prio_src_a", src_a, 32'hAA);
        m_reg_write = 0;
        #1 check("fwd_wb_src_a", src_a, 32'hBB);

        // x0 is never forwarded.
        set_idle();
        d_valid = 1; d_rs2 = 0; d_rd2 = 0; d_alu_src = 0;
        tick();
        m_rd = 0; m_reg_write = 1; m_alu_result = 32'hFFFF_FFFF;
        #1;
        check("x0_src_b", src_b, 0);
        check("x0_write_data", write_data_e, 0);

        // Load-use: lw x7 in EX, add x8, x7, x1 in decode.
        set_idle();
        d_valid = 1; d_mem_read = 1; d_reg_write = 1; d_rd = 7; d_rs1 = 2;
        d_imm = 4; d_alu_src = 1; d_result_src = 1;
        tick();
        set_idle();
        d_valid = 1; d_rs1 = 7; d_rs2 = 1; d_rd = 8; d_reg_write = 1;
        d_rd1 = 32'hDEAD; d_rd2 = 5;
        #1 check("lu_stall_d", stall_d, 1);
        tick();
        check("lu_bubble_e_valid", e_valid, 0);
        check("lu_bubble_reg_write", reg_write_e, 0);
        check("lu_stall_released", stall_d, 0);
        tick();
        w_rd = 7; w_reg_write = 1; w_result = 32'h1234;
        #1;
        check("lu_fwd_wb_src_a", src_a, 32'h1234);
        check("lu_add_rd_e", rd_e, 8);

        // Flush together with load-use: bubble wins, stall_d still asserts.
        set_idle();
        d_valid = 1; d_mem_read = 1; d_reg_write = 1; d_rd = 9;
        tick();
        set_idle();
        d_valid = 1; d_rs1 = 2; d_rs2 = 9; d_mem_write = 1; d_imm = 8; d_alu_src = 1;
        flush_e = 1;
        #1 check("flush_lu_stall_d", stall_d, 1);
        tick();
        check("flush_e_valid", e_valid, 0);
        check("flush_mem_write_e", mem_write_e, 0);

        // Hold for three cycles with changing decode inputs.
        set_idle();
        d_valid = 1; d_pc = 32'h100; d_rd = 12; d_imm = 32'h55; d_reg_write = 1;
        tick();
        hold_e = 1;
        for (int i = 0; i < 3; i++) begin
            rand_decode();
            #1 check("hold_stall_d", stall_d, 1);
            tick();
            check("hold_pc_e", pc_e, 32'h100);
            check("hold_rd_e", rd_e, 12);
            check("hold_imm_e", imm_e, 32'h55);
            check("hold_e_valid", e_valid, 1);
        end
        set_idle();
        d_valid = 1; d_pc = 32'h200; d_rd = 13;
        tick();
        check("release_pc_e", pc_e, 32'h200);
        check("release_rd_e", rd_e, 13);

        // Asynchronous reset mid-operation.
        set_idle();
        d_valid = 1; d_pc = 32'h300; d_rd = 6; d_reg_write = 1;
        tick();
        check("pre_rst_pc_e", pc_e, 32'h300);
        rst_n = 1'b0;
        #1;
        check("async_rst_e_valid", e_valid, 0);
        check("async_rst_pc_e", pc_e, 0);
        check("async_rst_reg_write", reg_write_e, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run, with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rand_all();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
